temp_bcd_conv: RTL and testbench

Sequential successor to the combinational temperature-to-display decoder. It accepts one 12-bit two's-complement temperature sample (0.0625 °C/LSB) over a valid/ready handshake. It converts the true magnitude to BCD with a one-bit-per-cycle double-dabble engine and emits sign, hundreds, tens, ones and a parametrised number of fraction digits for the 7-segment driver. It also maintains an over-temperature alarm with hysteresis and sits between the sensor-read controller and the digit-scan driver.

---
 rtl/temp_disp_pkg.sv | 48 ++++
 rtl/bin2bcd_seq.sv | 58 +++++
 rtl/temp_bcd_conv.sv | 152 +++++++++++++++
 tb/tb_temp_bcd_conv.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/temp_disp_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the
// temperature-to-BCD display path.
package temp_disp_pkg;

   localparam logic [3:0] SIGN_POS   = 4'hA;
   localparam logic [3:0] SIGN_NEG   = 4'hB;
   localparam logic [3:0] BLANK      = 4'hF;

   localparam int SCALE      = 625;
   localparam int SCALE_W    = $clog2(SCALE + 1);
   localparam int RAW_W      = 12;
   localparam int PROD_W     = 21;
   localparam int BCD_DIGITS = 7;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CONV = 1'b1
   } conv_state_e;

   // Magnitude times 625 (0.0625 degC per LSB in units of 0.0001 degC),
   // built from the set bits of SCALE as shift-adds (512+64+32+16+1).
   function automatic logic [PROD_W-1:0] scale_mag(input logic [RAW_W-1:0] mag);
      logic [PROD_W-1:0] ext;
      logic [PROD_W-1:0] acc;
      ext = {{(PROD_W-RAW_W){1'b0}}, mag};
      acc = '0;
      for (int b = 0; b < SCALE_W; b++) begin
         if (SCALE[b]) begin
            acc = acc + (ext << b);
         end else begin
            acc = acc;
         end
      end
      return acc;
   endfunction

   // Double-dabble correction of one BCD digit ahead of a left shift.
   function automatic logic [3:0] dabble_digit(input logic [3:0] d);
      logic [3:0] r;
      if (d >= 4'd5) begin
         r = d + 4'd3;
      end else begin
         r = d;
      end
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per clock.
// 'done' is high during the cycle whose rising edge performs the final
// shift; 'bcd' carries the value that shift produces, so the caller can
// register the finished result on that same edge.
module bin2bcd_seq
   import temp_disp_pkg::*;
#(
   parameter int BIN_W  = 21,
   parameter int DIGITS = 7
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int              CNT_W = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(BIN_W - 1);

   logic [BIN_W-1:0]    bin_r;
   logic [4*DIGITS-1:0] bcd_r;
   logic [4*DIGITS-1:0] adj_s;
   logic [CNT_W-1:0]    cnt_r;
   logic                run_r;

   // Add 3 to every digit that is 5 or more before it is shifted.
   always_comb begin
      adj_s = bcd_r;
      for (int i = 0; i < DIGITS; i++) begin
         adj_s[4*i +: 4] = dabble_digit(bcd_r[4*i +: 4]);
      end
   end

   assign done = run_r && (cnt_r == LAST);
   assign bcd  = {adj_s[4*DIGITS-2:0], bin_r[BIN_W-1]};

   // Load a fresh operand or advance the shift register by one bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_r <= '0;
         bcd_r <= '0;
         cnt_r <= '0;
         run_r <= 1'b0;
      end else if (load) begin
         bin_r <= bin_in;
         bcd_r <= '0;
         cnt_r <= '0;
         run_r <= 1'b1;
      end else if (run_r) begin
         {bcd_r, bin_r} <= {adj_s[4*DIGITS-2:0], bin_r, 1'b0};
         cnt_r          <= cnt_r + CNT_W'(1);
         run_r          <= !done;
      end
   end

endmodule

// File: rtl/temp_bcd_conv.sv
// Temperature sample to 7-segment digit codes: handshake, sign/magnitude,
// x625 scaling, sequential BCD conversion, digit selection, leading-zero
// blanking and over-temperature alarm with hysteresis.
module temp_bcd_conv
   import temp_disp_pkg::*;
#(
   parameter int                       FRAC_DIGITS = 3,
   parameter logic signed [RAW_W-1:0]  ALARM_HI    = 12'sd448,
   parameter logic [RAW_W-1:0]         ALARM_HYST  = 12'd16,
   parameter bit                       LZ_BLANK    = 1'b1
) (
   input  logic                           sys_clk,
   input  logic                           sys_rst_n,
   input  logic [15:0]                    t_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [4*(4+FRAC_DIGITS)-1:0]   dis_data,
   output logic                           out_valid,
   output logic                           en
);

   // Alarm release point, one bit wider so the subtraction cannot wrap.
   localparam logic signed [RAW_W:0] ALARM_LO =
      $signed({ALARM_HI[RAW_W-1], ALARM_HI}) - $signed({1'b0, ALARM_HYST});

   localparam int FRAC_TOP = 4*(BCD_DIGITS-3) - 1;

   conv_state_e                    state_r;
   logic signed [RAW_W-1:0]        raw_r;
   logic [RAW_W-1:0]               raw_s;
   logic [RAW_W-1:0]               mag_s;
   logic [PROD_W-1:0]              prod_s;
   logic                           load_s;
   logic                           done_s;
   logic [4*BCD_DIGITS-1:0]        bcd_s;
   logic [3:0]                     hund_s;
   logic [3:0]                     tens_s;
   logic [3:0]                     ones_s;
   logic [3:0]                     hund_disp_s;
   logic [3:0]                     tens_disp_s;
   logic [3:0]                     sign_s;
   logic [4*(4+FRAC_DIGITS)-1:0]   dis_next_s;
   logic                           en_next_s;
   logic                           unused_s;

   assign raw_s  = t_data[RAW_W-1:0];
   assign load_s = in_valid && in_ready;
   assign prod_s = scale_mag(mag_s);

   // Fraction digits below FRAC_DIGITS are truncated; upper sensor bits unused.
   assign unused_s = ^{t_data[15:RAW_W], bcd_s};

   // True magnitude; -2048 maps to 2048 exactly in 12 unsigned bits.
   always_comb begin
      if (raw_s[RAW_W-1]) begin
         mag_s = ~raw_s + 12'd1;
      end else begin
         mag_s = raw_s;
      end
   end

   bin2bcd_seq #(
      .BIN_W  (PROD_W),
      .DIGITS (BCD_DIGITS)
   ) u_bin2bcd (
      .clk    (sys_clk),
      .rst_n  (sys_rst_n),
      .load   (load_s),
      .bin_in (prod_s),
      .done   (done_s),
      .bcd    (bcd_s)
   );

   assign hund_s = bcd_s[4*BCD_DIGITS-1 -: 4];
   assign tens_s = bcd_s[4*BCD_DIGITS-5 -: 4];
   assign ones_s = bcd_s[4*BCD_DIGITS-9 -: 4];

   // Leading-zero blanking of hundreds and tens; ones is always shown.
   always_comb begin
      if (LZ_BLANK && (hund_s == 4'd0)) begin
         hund_disp_s = BLANK;
         if (tens_s == 4'd0) begin
            tens_disp_s = BLANK;
         end else begin
            tens_disp_s = tens_s;
         end
      end else begin
         hund_disp_s = hund_s;
         tens_disp_s = tens_s;
      end
   end

   // Sign code from the latched sample; zero counts as positive.
   always_comb begin
      if (raw_r[RAW_W-1]) begin
         sign_s = SIGN_NEG;
      end else begin
         sign_s = SIGN_POS;
      end
   end

   assign dis_next_s = {sign_s, hund_disp_s, tens_disp_s, ones_s,
                        bcd_s[FRAC_TOP -: 4*FRAC_DIGITS]};

   // Alarm with hysteresis on the signed raw sample.
   always_comb begin
      if (raw_r >= ALARM_HI) begin
         en_next_s = 1'b1;
      end else if ($signed({raw_r[RAW_W-1], raw_r}) < ALARM_LO) begin
         en_next_s = 1'b0;
      end else begin
         en_next_s = en;
      end
   end

   // Control FSM: accept a sample, wait for the final shift, publish outputs.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r   <= IDLE;
         in_ready  <= 1'b1;
         raw_r     <= '0;
         dis_data  <= '0;
         out_valid <= 1'b0;
         en        <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  raw_r    <= raw_s;
                  in_ready <= 1'b0;
                  state_r  <= CONV;
               end
            end
            CONV: begin
               if (done_s) begin
                  dis_data  <= dis_next_s;
                  en        <= en_next_s;
                  out_valid <= 1'b1;
                  in_ready  <= 1'b1;
                  state_r   <= IDLE;
               end
            end
            default: begin
               in_ready <= 1'b1;
               state_r  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_temp_bcd_conv.sv
// Directed bench for temp_bcd_conv: default build plus a one-fraction-digit
// build and a no-blanking build driven by the same stimulus.
module tb_temp_bcd_conv;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic [15:0] t_data;
   logic        in_valid;

   logic        in_ready,  out_valid,  en;
   logic [27:0] dis_data;
   logic        in_ready_f1, out_valid_f1, en_f1;
   logic [19:0] dis_data_f1;
   logic        in_ready_nb, out_valid_nb, en_nb;
   logic [27:0] dis_data_nb;

   int checks = 0;
   int errors = 0;

   always #5 sys_clk = ~sys_clk;

   temp_bcd_conv dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .t_data(t_data), .in_valid(in_valid),
      .in_ready(in_ready), .dis_data(dis_data), .out_valid(out_valid), .en(en));

   temp_bcd_conv #(.FRAC_DIGITS(1)) dut_f1 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .t_data(t_data), .in_valid(in_valid),
      .in_ready(in_ready_f1), .dis_data(dis_data_f1), .out_valid(out_valid_f1), .en(en_f1));

   temp_bcd_conv #(.LZ_BLANK(1'b0)) dut_nb (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .t_data(t_data), .in_valid(in_valid),
      .in_ready(in_ready_nb), .dis_data(dis_data_nb), .out_valid(out_valid_nb), .en(en_nb));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One sample through the default DUT with latency, pulse and result checks.
   task automatic convert(input logic [15:0] data, input logic [27:0] exp_dis,
                          input logic exp_en, input string tag);
      int k;
      bit seen;
      @(negedge sys_clk);
      chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
      t_data   = data;
      in_valid = 1'b1;
      @(posedge sys_clk);
      #1;
      in_valid = 1'b0;
      t_data   = 16'($urandom);
      chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
      seen = 1'b0;
      k    = 0;
      while (!seen && k < 40) begin
         @(negedge sys_clk);
         k++;
         if (out_valid) seen = 1'b1;
      end
      chk({tag, "_lat"}, seen ? k - 1 : -1, 32'd21);
      chk({tag, "_dis"}, {4'd0, dis_data}, {4'd0, exp_dis});
      chk({tag, "_en"}, {31'd0, en}, {31'd0, exp_en});
      chk({tag, "_rdy_out"}, {31'd0, in_ready}, 32'd1);
      @(negedge sys_clk);
      chk({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
   endtask

   logic [15:0] tbl     [5] = '{16'h01B8, 16'h07D0, 16'h0001, 16'h0000, 16'hFC90};
   logic [27:0] exp_tbl [5] = '{28'hAF27500, 28'hA125000, 28'hAFF0062, 28'hAFF0000, 28'hBF55000};

   initial begin
      int pend;
      int last_acc;
      int n_acc;
      int n_res;
      int k;
      int pulses;

      sys_rst_n = 1'b0;
      in_valid  = 1'b0;
      t_data    = 16'h0000;
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_ovalid", {31'd0, out_valid}, 32'd0);
      chk("rst_en", {31'd0, en}, 32'd0);
      chk("rst_dis", {4'd0, dis_data}, 32'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;

      // Main function and parameter variants.
      convert(16'h01B8, 28'hAF27500, 1'b0, "t27p5");
      chk("t27p5_f1", {12'd0, dis_data_f1}, 32'h000AF275);
      chk("t27p5_nb", {4'd0, dis_data_nb}, 32'h0A027500);
      convert(16'h07D0, 28'hA125000, 1'b1, "t125");
      convert(16'hFC90, 28'hBF55000, 1'b0, "tm55");

      // Alarm hysteresis.
      convert(16'h01C0, 28'hAF28000, 1'b1, "h448");
      convert(16'h01B8, 28'hAF27500, 1'b1, "h440");
      convert(16'h01B0, 28'hAF27000, 1'b1, "h432");
      convert(16'h01AF, 28'hAF26937, 1'b0, "h431");
      convert(16'h01BF, 28'hAF27937, 1'b0, "h447");
      convert(16'h01C0, 28'hAF28000, 1'b1, "h448b");

      // Boundaries.
      convert(16'h0001, 28'hAFF0062, 1'b0, "lsb");
      chk("lsb_f1", {12'd0, dis_data_f1}, 32'h000AFF00);
      chk("lsb_nb", {4'd0, dis_data_nb}, 32'h0A000062);
      convert(16'h0FFF, 28'hBFF0062, 1'b0, "m1");
      convert(16'h0000, 28'hAFF0000, 1'b0, "zero");
      convert(16'h0800, 28'hB128000, 1'b0, "min");
      chk("min_f1", {12'd0, dis_data_f1}, 32'h000B1280);
      chk("min_nb", {4'd0, dis_data_nb}, 32'h0B128000);

      // Back-to-back throughput with t_data changing every cycle.
      @(negedge sys_clk);
      in_valid = 1'b1;
      pend     = -1;
      last_acc = -1;
      n_acc    = 0;
      n_res    = 0;
      for (int c = 0; c < 70; c++) begin
         t_data = tbl[c % 5];
         if (out_valid && pend >= 0) begin
            chk("thr_dis", {4'd0, dis_data}, {4'd0, exp_tbl[pend]});
            n_res++;
         end
         if (in_ready) begin
            if (last_acc >= 0) chk("thr_gap", c - last_acc, 32'd22);
            last_acc = c;
            pend     = c % 5;
            n_acc++;
         end
         @(negedge sys_clk);
      end
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 40) begin
         @(negedge sys_clk);
         k++;
      end
      chk("thr_last_seen", {31'd0, out_valid}, 32'd1);
      chk("thr_last_dis", {4'd0, dis_data}, {4'd0, exp_tbl[pend]});
      chk("thr_accepts", n_acc, 32'd4);
      chk("thr_results", n_res, 32'd3);

      // Reset in the middle of a conversion.
      convert(16'h01C0, 28'hAF28000, 1'b1, "pre_rst");
      @(negedge sys_clk);
      t_data   = 16'h07D0;
      in_valid = 1'b1;
      @(posedge sys_clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      chk("mid_rst_ovalid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_en", {31'd0, en}, 32'd0);
      chk("mid_rst_dis", {4'd0, dis_data}, 32'd0);
      chk("mid_rst_f1", {12'd0, dis_data_f1, in_ready_f1, out_valid_f1, en_f1}, 32'h00000004);
      chk("mid_rst_nb", {1'b0, dis_data_nb, in_ready_nb, out_valid_nb, en_nb}, 32'h00000004);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      pulses = 0;
      repeat (30) begin
         @(negedge sys_clk);
         if (out_valid) pulses++;
      end
      chk("mid_rst_no_pulse", pulses, 32'd0);
      convert(16'h01B8, 28'hAF27500, 1'b0, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
